// File: rtl/csr_unit_if.sv
// CSR unit bus: stage-2 instruction/operand inputs and CSR result outputs.
// The master drives the decode-side signals; the slave (csr_unit) returns results.
// clk and rst are not part of the bundle; they stay plain ports on the module.
interface csr_unit_if;
  logic [31:0] instruction_s2;
  logic        csr_we;
  logic [31:0] rs1_data;
  logic        stall;
  logic        retire;
  logic [31:0] csr_rdata;
  logic [31:0] tohost;
  logic        tohost_valid;
  logic [31:0] cycle_lo;

  modport master (
    output instruction_s2, csr_we, rs1_data, stall, retire,
    input  csr_rdata, tohost, tohost_valid, cycle_lo
  );

  modport slave (
    input  instruction_s2, csr_we, rs1_data, stall, retire,
    output csr_rdata, tohost, tohost_valid, cycle_lo
  );
endinterface

// File: rtl/csr_unit.sv
// CSR unit: tohost register plus 64-bit cycle/instret counters, CSRRW/CSRRWI access.
// Latency 1: csr_rdata and tohost_valid appear the cycle after the accepted access.
// stall holds off CSR accesses and instret counting; cycle always counts.
module csr_unit (
  input  logic     clk,
  input  logic     rst,
  csr_unit_if.slave bus
);

  localparam logic [11:0] ADDR_TOHOST    = 12'h51E;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
  localparam logic [2:0]  F3_CSRRW       = 3'b001;
  localparam logic [2:0]  F3_CSRRWI      = 3'b101;

  logic [63:0] r_cycle;
  logic [63:0] r_instret;
  logic [31:0] r_tohost;
  logic [31:0] r_rdata;
  logic        r_tohost_vld;

  logic [11:0] w_addr;
  logic [2:0]  w_func3;
  logic [4:0]  w_uimm;
  logic        w_accept;
  logic        w_is_tohost;
  logic        w_instret_inc;
  logic [31:0] w_wdata;
  logic [31:0] w_rd_val;
  logic        w_unused;

  assign w_addr        = bus.instruction_s2[31:20];
  assign w_func3       = bus.instruction_s2[14:12];
  assign w_uimm        = bus.instruction_s2[19:15];
  // Only CSRRW/CSRRWI are implemented; any other func3 is a no-op.
  assign w_accept      = bus.csr_we && !bus.stall &&
                         ((w_func3 == F3_CSRRW) || (w_func3 == F3_CSRRWI));
  assign w_is_tohost   = (w_addr == ADDR_TOHOST);
  assign w_instret_inc = bus.retire && !bus.stall;
  assign w_wdata       = (w_func3 == F3_CSRRWI) ? {27'b0, w_uimm} : bus.rs1_data;
  // Opcode/rd fields are decoded upstream into csr_we.
  assign w_unused      = ^bus.instruction_s2[11:0];

  // Read mux over pre-update state so a concurrent increment/write is not seen.
  always_comb begin
    w_rd_val = 32'd0;
    case (w_addr)
      ADDR_TOHOST:   w_rd_val = r_tohost;
      ADDR_CYCLE:    w_rd_val = r_cycle[31:0];
      ADDR_CYCLEH:   w_rd_val = r_cycle[63:32];
      ADDR_INSTRET:  w_rd_val = r_instret[31:0];
      ADDR_INSTRETH: w_rd_val = r_instret[63:32];
      default:       w_rd_val = 32'd0;
    endcase
  end

  // Free-running 64-bit cycle counter; one wide add keeps the halves consistent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle <= 64'd0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
    end
  end

  // Retired-instruction counter, frozen while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instret <= 64'd0;
    end else if (w_instret_inc) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  // tohost is the only writable CSR; the pulse flags every accepted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tohost     <= 32'd0;
      r_tohost_vld <= 1'b0;
    end else begin
      r_tohost_vld <= w_accept && w_is_tohost;
      if (w_accept && w_is_tohost) begin
        r_tohost <= w_wdata;
      end
    end
  end

  // Read data captures the old CSR value and holds until the next access.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 32'd0;
    end else if (w_accept) begin
      r_rdata <= w_rd_val;
    end
  end

  assign bus.csr_rdata    = r_rdata;
  assign bus.tohost       = r_tohost;
  assign bus.tohost_valid = r_tohost_vld;
  assign bus.cycle_lo     = r_cycle[31:0];

endmodule

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001: Ports SHALL be: clk  input  1  sole clock, all state updates on rising edge.
REQ-002: rst  input  1  synchronous reset, active-high.
REQ-003: instruction_s2  input  32  stage-2 instruction; CSR address = [31:12+8..20], func3 = [14:12], uimm = [19:15].
REQ-004: csr_we  input  1  stage-2 decode flag, high when opcode is OPC_CSR.
REQ-005: rs1_data  input  32  forwarded rs1 operand for stage 2.
REQ-006: stall  input  1  pipeline hold; when high, no CSR write and no instret increment.
REQ-007: retire  input  1  one instruction retires this cycle.
REQ-008: csr_rdata  output  32  registered old value of the addressed CSR.
REQ-009: tohost  output  32  current tohost CSR value.
REQ-010: tohost_valid  output  1  one-cycle pulse after each accepted tohost write.
REQ-011: cycle_lo  output  32  cycle counter bits [31:0], for debug.

Function
REQ-012: CSR address SHALL be instruction_s2[31:20].
REQ-013: Access SHALL be accepted when csr_we=1, stall=0 and func3 is 3'b001 (CSRRW) or 3'b101 (CSRRWI); all other func3 values SHALL be ignored with no state change.
REQ-014: Write data SHALL be rs1_data for CSRRW and {27'b0, instruction_s2[19:15]} for CSRRWI.
REQ-015: Address map: 0x51E tohost (RW, 32b); 0xC00 cycle[31:0], 0xC80 cycle[63:32], 0xC02 instret[31:0], 0xC82 instret[63:32] (all RO).
REQ-016: Writes to RO addresses SHALL be discarded; the read side still executes.
REQ-017: Unmapped addresses SHALL read as 0 and discard writes.
REQ-018: On an accepted access, csr_rdata SHALL present the CSR value before that cycle's write or increment, on the following cycle (latency 1). It SHALL hold that value until the next accepted access.
REQ-019: An accepted write to 0x51E SHALL update tohost at the same clock edge. tohost_valid SHALL be 1 for exactly the next cycle, even when the written value equals the old value.
REQ-020: Back-to-back tohost writes SHALL produce back-to-back tohost_valid pulses, one per write.
REQ-021: cycle SHALL be a 64-bit counter that increments by 1 every cycle rst=0, regardless of stall. It SHALL wrap from 2^64-1 to 0.
REQ-022: instret SHALL be a 64-bit counter that increments by 1 on cycles with retire=1 and stall=0. It SHALL wrap from 2^64-1 to 0.
REQ-023: Carry from the low to the high 32 bits SHALL occur in the same cycle, so no torn value is ever observable.
REQ-024: A read of a counter concurrent with its increment SHALL return the pre-increment value.
REQ-025: When stall=1 with csr_we=1, the access SHALL be ignored; the held instruction is re-presented later and accepted exactly once, when stall drops.

Reset
REQ-026: While rst=1 (sampled at clk edge), the following SHALL be cleared to 0: cycle, instret, tohost, csr_rdata, tohost_valid.
REQ-027: rst asserted mid-operation SHALL override same-cycle writes, increments and pending pulses; the pending tohost_valid SHALL NOT fire.
REQ-028: The first cycle after rst deasserts SHALL count as cycle 0 → 1.

Verification
REQ-029: Release reset, idle 10 cycles, then CSRRW from 0xC00 -> csr_rdata=10 one cycle later; cycle_lo=11 at that time.
REQ-030: CSRRW to 0x51E with rs1_data=0x0000_0001 -> tohost=1 next cycle, with tohost_valid high exactly 1 cycle; then CSRRWI 0x51E uimm=5 -> csr_rdata=1, tohost=5, second pulse.
REQ-031: CSRRW to 0x51E with stall=1 for 3 cycles, then stall=0 -> exactly one write and one tohost_valid pulse, after stall drops.
REQ-032: retire=1 for 7 cycles with stall high on 2 of them -> read 0xC02 returns 5; a write of 0xFFFF_FFFF to 0xC02 is discarded.
REQ-033: Force cycle to 0x0000_0000_FFFF_FFFF (via backdoor), then read 0xC00 -> 0xFFFF_FFFF; next-cycle read of 0xC80 -> 0x0000_0001.
REQ-034: Assert rst in the same cycle as an accepted tohost write of 0xAA -> tohost=0, with no tohost_valid pulse and all counters 0.
